// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
//
// Shared definitions for the sequential arithmetic blocks of the datapath.
//
// Contents:
//   SUB_WIDTH   - default operand width of serial_subtractor
//   sub_state_t - serial_subtractor controller states (IDLE, SHIFT, DONE)
// -----------------------------------------------------------------------------
package arith_pkg;

  localparam int SUB_WIDTH = 4;

  // Encodings are fixed so the debug state port decodes the same way in
  // every build.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
//
// One-bit full subtractor cell computing a - b - bin. It is built from
// explicit gate terms so it maps one-to-one onto the full adder cell used by
// the ripple-carry adders.
//
// Ports:
//   a    in  minuend bit
//   b    in  subtrahend bit
//   bin  in  borrow-in
//   diff out difference bit   = a ^ b ^ bin
//   bout out borrow-out       = ~a&b | ~a&bin | b&bin
// -----------------------------------------------------------------------------
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic a_n;
  logic ab_x;
  logic t_ab;
  logic t_abin;
  logic t_bbin;

  assign a_n    = ~a;
  assign ab_x   = a ^ b;
  assign diff   = ab_x ^ bin;

  // Majority of (~a, b, bin): a borrow is needed whenever the subtracted
  // quantities outweigh the minuend bit.
  assign t_ab   = a_n & b;
  assign t_abin = a_n & bin;
  assign t_bbin = b & bin;
  assign bout   = t_ab | t_abin | t_bbin;

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial WIDTH-bit subtractor computing a - b - bin, LSB first, using one
// full_subtractor cell over WIDTH clock cycles.
//
// Handshake: start is sampled on a rising edge only while busy is low (IDLE or
// DONE). The edge that samples it captures a, b and bin. busy is then high for
// exactly WIDTH cycles, followed by a one-cycle done pulse in which diff and
// bout carry the result. start seen in the done cycle begins the next operation
// back-to-back. start while busy is ignored. diff and bout hold their value
// until a new operation starts shifting.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-high reset
//   start     in   operation request
//   a         in   [WIDTH-1:0] minuend
//   b         in   [WIDTH-1:0] subtrahend
//   bin       in   borrow-in
//   busy      out  high while shifting
//   done      out  one-cycle result-valid pulse
//   diff      out  [WIDTH-1:0] (a - b - bin) mod 2^WIDTH
//   bout      out  final borrow-out (a < b + bin)
//   dbg_state out  [1:0] controller state (arith_pkg::sub_state_t encoding)
// -----------------------------------------------------------------------------
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic [1:0]       dbg_state
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             busy_r;
  logic             done_r;

  logic             cell_d;
  logic             cell_bout;

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .diff (cell_d),
    .bout (cell_bout)
  );

  // busy and done are kept as their own flops, set alongside the state
  // transition, so the outputs come straight from registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            borrow  <= bin;
            diff_sr <= '0;
            cnt     <= '0;
            busy_r  <= 1'b1;
            state   <= SHIFT;
          end else begin
            state   <= IDLE;
          end
        end
        SHIFT: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          borrow  <= cell_bout;
          // Result bits enter at the MSB; after WIDTH shifts the first
          // (LSB) difference bit has reached bit 0.
          diff_sr <= {cell_d, diff_sr[WIDTH-1:1]};
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            busy_r <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign diff      = diff_sr;
  // After the last shift the borrow flop holds the final borrow-out, and it
  // is not touched again until the next operation is accepted.
  assign bout      = borrow;
  assign dbg_state = 2'(state);

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor: a WIDTH=4 instance for the
// directed cases and the exhaustive sweep, and a WIDTH=8 instance for a
// wider randomised sweep.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       bin4;
  logic       busy4;
  logic       done4;
  logic [3:0] diff4;
  logic       bout4;
  logic [1:0] st4;

  // WIDTH=8 instance
  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       bin8;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       bout8;
  logic [1:0] st8;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .dbg_state(st4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .dbg_state(st8)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / reporting
  // ---------------------------------------------------------------------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b,
                                      input logic bin);
    return {1'b0, a} - {1'b0, b} - {4'b0, bin};
  endfunction

  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                      input logic bin);
    return {1'b0, a} - {1'b0, b} - {8'b0, bin};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks: one operation each, returns at the done cycle (or timeout)
  // ---------------------------------------------------------------------------
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                     output logic ok, output logic [4:0] res, output int lat);
    a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
    step();
    start4 = 1'b0;
    lat = 1;
    while (!done4 && lat < 20) begin
      step();
      lat++;
    end
    ok  = done4;
    res = {bout4, diff4};
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     output logic ok, output logic [8:0] res, output int lat);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    step();
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 30) begin
      step();
      lat++;
    end
    ok  = done8;
    res = {bout8, diff8};
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table (hand-computed results)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] diff;
    logic       bout;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic       ok;
    logic [4:0] res;
    logic [8:0] res8;
    int         lat;
    int         n;
    logic [3:0] ha[4];
    logic [3:0] hb[4];
    logic       hbin[4];

    vecs[0] = '{4'h9, 4'h5, 1'b0, 4'h4, 1'b0};
    vecs[1] = '{4'h3, 4'h5, 1'b0, 4'hE, 1'b1};
    vecs[2] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    vecs[3] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
    vecs[4] = '{4'h0, 4'h1, 1'b0, 4'hF, 1'b1};
    vecs[5] = '{4'h8, 4'h1, 1'b1, 4'h6, 1'b0};

    rst = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    step();

    // Reset state
    check("reset_busy_done", {busy4, done4}, 2'b00);
    check("reset_result", {bout4, diff4}, 5'h00);
    check("reset_state", st4, 2'd0);
    check("reset_w8", {busy8, done8, bout8, diff8}, 11'h000);
    rst = 1'b0;
    step();

    // 9 - 5: cycle-by-cycle busy/done timing
    a4 = 4'h9; b4 = 4'h5; bin4 = 1'b0; start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("t1_busy_c%0d", c), {busy4, done4}, 2'b10);
      step();
    end
    check("t1_done", {busy4, done4}, 2'b01);
    check("t1_result", {bout4, diff4}, 5'h04);
    check("t1_state_done", st4, 2'd2);
    step();
    check("t1_idle_hold", {busy4, done4, bout4, diff4}, 7'b0000100);
    check("t1_state_idle", st4, 2'd0);

    // Directed table, issued back-to-back from the done cycle
    for (int i = 0; i < 6; i++) begin
      op4(vecs[i].a, vecs[i].b, vecs[i].bin, ok, res, lat);
      check($sformatf("vec%0d_latency", i), lat, 5);
      check($sformatf("vec%0d_result", i), {ok, res},
            {1'b1, vecs[i].bout, vecs[i].diff});
    end
    step();

    // start during busy is ignored: 7 - 2 wins over the later 1 - 1
    a4 = 4'h7; b4 = 4'h2; bin4 = 1'b0; start4 = 1'b1;
    step();
    start4 = 1'b0;
    step();
    a4 = 4'h1; b4 = 4'h1; start4 = 1'b1;
    step();
    start4 = 1'b0; a4 = '0; b4 = '0;
    n = 0;
    while (!done4 && n < 20) begin
      step();
      n++;
    end
    check("ign_done_cycle", n, 2);
    check("ign_result", {done4, bout4, diff4}, 6'b100101);
    step();
    step();
    check("ign_hold", {busy4, done4, bout4, diff4}, 7'b0000101);
    check("ign_state_idle", st4, 2'd0);

    // start held high: a new operation in every done cycle
    ha[0] = 4'h9; hb[0] = 4'h3; hbin[0] = 1'b0;
    ha[1] = 4'h2; hb[1] = 4'h7; hbin[1] = 1'b1;
    ha[2] = 4'hF; hb[2] = 4'h0; hbin[2] = 1'b1;
    ha[3] = 4'h4; hb[3] = 4'h4; hbin[3] = 1'b0;
    a4 = ha[0]; b4 = hb[0]; bin4 = hbin[0]; start4 = 1'b1;
    exp_q.push_back(ref4(ha[0], hb[0], hbin[0]));
    step();
    for (int k = 0; k < 4; k++) begin
      // Change operands mid-shift: they must not be re-sampled.
      a4 = ~ha[k]; b4 = ~hb[k];
      n = 0;
      while (!done4 && n < 20) begin
        step();
        n++;
      end
      check($sformatf("held%0d_spacing", k), n, 4);
      check($sformatf("held%0d_result", k), {done4, bout4, diff4},
            {1'b1, exp_q.pop_front()});
      if (k < 3) begin
        a4 = ha[k+1]; b4 = hb[k+1]; bin4 = hbin[k+1];
        exp_q.push_back(ref4(ha[k+1], hb[k+1], hbin[k+1]));
      end else begin
        start4 = 1'b0;
      end
      step();
    end
    check("held_state_idle", st4, 2'd0);
    check("held_queue_empty", exp_q.size(), 0);

    // Asynchronous reset in the second SHIFT cycle of 6 - 3
    a4 = 4'h6; b4 = 4'h3; bin4 = 1'b0; start4 = 1'b1;
    step();
    start4 = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    check("rst_mid_outputs", {busy4, done4, bout4, diff4}, 7'b0);
    check("rst_mid_state", st4, 2'd0);
    #1 rst = 1'b0;
    step();
    check("rst_after_idle", {busy4, done4, st4}, 4'b0);
    op4(4'h6, 4'h6, 1'b0, ok, res, lat);
    check("rst_next_latency", lat, 5);
    check("rst_next_result", {ok, res}, 6'b100000);
    step();

    // Exhaustive WIDTH=4 sweep against the reference model
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          op4(4'(ia), 4'(ib), 1'(ic), ok, res, lat);
          check($sformatf("sweep4_%0h_%0h_%0d", ia, ib, ic), {ok, res},
                {1'b1, ref4(4'(ia), 4'(ib), 1'(ic))});
        end
      end
    end
    step();

    // WIDTH=8: corners then random operands
    op8(8'h00, 8'h00, 1'b0, ok, res8, lat);
    check("w8_zero", {ok, res8}, 10'b10_0000_0000);
    check("w8_latency", lat, 9);
    op8(8'hFF, 8'hFF, 1'b1, ok, res8, lat);
    check("w8_ff_ff_1", {ok, res8}, 10'b11_1111_1111);
    op8(8'h00, 8'hFF, 1'b1, ok, res8, lat);
    check("w8_00_ff_1", {ok, res8}, 10'b11_0000_0000);
    op8(8'hC8, 8'h37, 1'b0, ok, res8, lat);
    check("w8_c8_37_0", {ok, res8}, 10'b10_1001_0001);
    for (int r = 0; r < 120; r++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      op8(ra, rb, rc, ok, res8, lat);
      check($sformatf("w8_rand_%0h_%0h_%0d", ra, rb, rc), {ok, res8},
            {1'b1, ref8(ra, rb, rc)});
    end
    step();
    check("w8_final_idle", {busy8, done8, st8}, 4'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
